// File: rtl/regfile_write_arbiter.sv
// Two-source (ALU / load) writeback arbiter for a register file.
// Each source owns a one-entry hold slot; oldest slot wins, round-robin breaks ties.
module regfile_write_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aluValid,
    input  logic [ADDR_W-1:0] aluReg,
    input  logic [DATA_W-1:0] aluData,
    output logic              aluReady,
    input  logic              memValid,
    input  logic [ADDR_W-1:0] memReg,
    input  logic [DATA_W-1:0] memData,
    output logic              memReady,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic [31:0]       busyMask,
    output logic [7:0]        stallCount
);

    typedef enum logic [1:0] {
        AGE_TIE       = 2'd0,
        AGE_ALU_OLDER = 2'd1,
        AGE_MEM_OLDER = 2'd2
    } age_e;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    logic              aluFull_q, aluFull_d;
    logic [ADDR_W-1:0] aluSlotReg_q, aluSlotReg_d;
    logic [DATA_W-1:0] aluSlotData_q, aluSlotData_d;
    logic              memFull_q, memFull_d;
    logic [ADDR_W-1:0] memSlotReg_q, memSlotReg_d;
    logic [DATA_W-1:0] memSlotData_q, memSlotData_d;
    age_e              age_q, age_d;
    src_e              rrPtr_q, rrPtr_d;
    logic              regWrite_q, regWrite_d;
    logic [ADDR_W-1:0] writeReg_q, writeReg_d;
    logic [DATA_W-1:0] writeData_q, writeData_d;
    logic [7:0]        stallCount_q, stallCount_d;

    logic grantAlu, grantMem, tieGrant;
    logic aluAccept, memAccept, aluLoad, memLoad, stallEvent;

    always_comb begin
        grantAlu = 1'b0;
        grantMem = 1'b0;
        tieGrant = 1'b0;
        if (aluFull_q && memFull_q) begin
            case (age_q)
                AGE_ALU_OLDER: grantAlu = 1'b1;
                AGE_MEM_OLDER: grantMem = 1'b1;
                default: begin
                    tieGrant = 1'b1;
                    if (rrPtr_q == SRC_ALU) begin
                        grantAlu = 1'b1;
                    end else begin
                        grantMem = 1'b1;
                    end
                end
            endcase
        end else if (aluFull_q) begin
            grantAlu = 1'b1;
        end else if (memFull_q) begin
            grantMem = 1'b1;
        end
    end

    // A slot can take a new request in the same cycle it drains.
    assign aluReady   = !aluFull_q || grantAlu;
    assign memReady   = !memFull_q || grantMem;
    assign aluAccept  = aluValid && aluReady;
    assign memAccept  = memValid && memReady;
    assign aluLoad    = aluAccept && (aluReg != '0);
    assign memLoad    = memAccept && (memReg != '0);
    assign stallEvent = (aluValid && !aluReady) || (memValid && !memReady);

    always_comb begin
        aluFull_d     = aluFull_q;
        aluSlotReg_d  = aluSlotReg_q;
        aluSlotData_d = aluSlotData_q;
        memFull_d     = memFull_q;
        memSlotReg_d  = memSlotReg_q;
        memSlotData_d = memSlotData_q;
        age_d         = age_q;
        rrPtr_d       = rrPtr_q;
        regWrite_d    = 1'b0;
        writeReg_d    = writeReg_q;
        writeData_d   = writeData_q;
        stallCount_d  = stallCount_q;

        if (aluLoad) begin
            aluFull_d     = 1'b1;
            aluSlotReg_d  = aluReg;
            aluSlotData_d = aluData;
        end else if (grantAlu) begin
            aluFull_d = 1'b0;
        end

        if (memLoad) begin
            memFull_d     = 1'b1;
            memSlotReg_d  = memReg;
            memSlotData_d = memData;
        end else if (grantMem) begin
            memFull_d = 1'b0;
        end

        // Whichever slot was not just loaded has been waiting longer.
        case ({aluFull_d, memFull_d})
            2'b11: begin
                if (aluLoad && memLoad) begin
                    age_d = AGE_TIE;
                end else if (aluLoad) begin
                    age_d = AGE_MEM_OLDER;
                end else if (memLoad) begin
                    age_d = AGE_ALU_OLDER;
                end
            end
            2'b10:   age_d = AGE_ALU_OLDER;
            2'b01:   age_d = AGE_MEM_OLDER;
            default: age_d = AGE_TIE;
        endcase

        if (tieGrant) begin
            rrPtr_d = grantAlu ? SRC_MEM : SRC_ALU;
        end

        if (grantAlu) begin
            regWrite_d  = 1'b1;
            writeReg_d  = aluSlotReg_q;
            writeData_d = aluSlotData_q;
        end else if (grantMem) begin
            regWrite_d  = 1'b1;
            writeReg_d  = memSlotReg_q;
            writeData_d = memSlotData_q;
        end

        if (stallEvent && (stallCount_q != 8'hFF)) begin
            stallCount_d = stallCount_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aluFull_q     <= 1'b0;
            aluSlotReg_q  <= '0;
            aluSlotData_q <= '0;
            memFull_q     <= 1'b0;
            memSlotReg_q  <= '0;
            memSlotData_q <= '0;
            age_q         <= AGE_TIE;
            rrPtr_q       <= SRC_ALU;
            regWrite_q    <= 1'b0;
            writeReg_q    <= '0;
            writeData_q   <= '0;
            stallCount_q  <= 8'd0;
        end else begin
            aluFull_q     <= aluFull_d;
            aluSlotReg_q  <= aluSlotReg_d;
            aluSlotData_q <= aluSlotData_d;
            memFull_q     <= memFull_d;
            memSlotReg_q  <= memSlotReg_d;
            memSlotData_q <= memSlotData_d;
            age_q         <= age_d;
            rrPtr_q       <= rrPtr_d;
            regWrite_q    <= regWrite_d;
            writeReg_q    <= writeReg_d;
            writeData_q   <= writeData_d;
            stallCount_q  <= stallCount_d;
        end
    end

    // Register 0 is never written, so its busy bit stays clear.
    always_comb begin
        busyMask = '0;
        for (int r = 1; r < 32; r++) begin
            busyMask[r] = (aluFull_q && (aluSlotReg_q == ADDR_W'(r))) ||
                          (memFull_q && (memSlotReg_q == ADDR_W'(r))) ||
                          (regWrite_q && (writeReg_q == ADDR_W'(r)));
        end
    end

    assign RegWrite   = regWrite_q;
    assign writeReg   = writeReg_q;
    assign writeData  = writeData_q;
    assign stallCount = stallCount_q;

endmodule
